// File: rtl/show_if.sv
// Display bus between the scan driver and its user.
// The user drives en/data; the driver returns the 74HC595 serial lines.
interface show_if;
  logic        en;
  logic [31:0] data;
  logic        sh_cp;
  logic        st_cp;
  logic        ds;

  modport master (
    output en, data,
    input  sh_cp, st_cp, ds
  );

  modport slave (
    input  en, data,
    output sh_cp, st_cp, ds
  );
endinterface

// File: rtl/show.sv
// 8-digit hex scanner driving two chained 74HC595 (SEG byte, then SEL byte).
// Optional macro SHOW_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module show #(
  parameter int SCAN_DIV  = 50000,
  parameter int SHIFT_DIV = 2
) (
  input logic   clk,
  input logic   reset_n,
  show_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    WAIT
  } state_t;

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(SHIFT_DIV + 1);

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] div_cnt;
  logic          phase;
  logic [3:0]    bit_cnt;
  logic [2:0]    digit;
  logic [15:0]   word_q;
  logic [15:0]   word_live;
  logic [3:0]    nib;
  logic [7:0]    seg;
  logic          blank;
  logic          div_end;
  logic          slot_end;
  logic          bit_end;
  logic          wrap;

  assign div_end  = div_cnt == DW'(SHIFT_DIV - 1);
  assign slot_end = slot_cnt == SW'(SCAN_DIV - 1);
  assign bit_end  = (state == SHIFT) && phase
                  && div_end && (bit_cnt == 4'd15);
  assign wrap     = ((state == WAIT) && slot_end)
                  || ((state == LATCH) && div_end && slot_end);

  assign nib = bus.data[{digit, 2'b00} +: 4];

`ifdef SHOW_LEADING_ZERO_BLANK_EN
  logic [2:0] msd;

  // Highest nonzero nibble; digit 0 stays lit when data is all zero.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++)
      if (bus.data[4*i +: 4] != 4'h0) msd = 3'(i);
  end

  assign blank = digit > msd;
`else
  assign blank = 1'b0;
`endif

  // Hex glyph lookup, active-low segments, dp off.
  always_comb begin
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
  end

  assign word_live = {blank ? 8'hFF : seg, ~(8'h01 << digit)};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and serial outputs.
  always_comb begin
    state_nx  = state;
    bus.sh_cp = 1'b0;
    bus.st_cp = 1'b0;
    bus.ds    = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        if (bus.en) state_nx = SHIFT;
      end
      state == SHIFT: begin
        bus.sh_cp = phase;
        bus.ds    = (slot_cnt == '0) ? word_live[15]
                                     : word_q[4'd15 - bit_cnt];
        if (bit_end) state_nx = LATCH;
      end
      state == LATCH: begin
        bus.st_cp = 1'b1;
        if (div_end) begin
          if (!slot_end)   state_nx = WAIT;
          else if (bus.en) state_nx = SHIFT;
          else             state_nx = IDLE;
        end
      end
      default: begin
        if (slot_end) state_nx = bus.en ? SHIFT : IDLE;
      end
    endcase
  end

  // Slot, shift-rate and bit counters, digit index, captured word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      div_cnt  <= '0;
      phase    <= 1'b0;
      bit_cnt  <= 4'd0;
      digit    <= 3'd0;
      word_q   <= 16'h0;
    end else begin
      if (state == IDLE || wrap) slot_cnt <= '0;
      else                       slot_cnt <= slot_cnt + SW'(1);

      if (state == SHIFT || state == LATCH)
        div_cnt <= div_end ? '0 : div_cnt + DW'(1);
      else
        div_cnt <= '0;

      if (state == SHIFT) begin
        if (div_end) phase <= ~phase;
        if (div_end && phase) bit_cnt <= bit_cnt + 4'd1;
        if (slot_cnt == '0) word_q <= word_live;
      end else begin
        phase   <= 1'b0;
        bit_cnt <= 4'd0;
      end

      if (wrap) digit <= digit + 3'd1;
    end
  end

endmodule

// File: tb/tb_show.sv
// Bench for show: frames decoded from the serial lines,
// compared with a glyph/position model of the display.
module tb_show;

  localparam int SCAN = 100;
  localparam int SDIV = 2;

  typedef struct {
    logic [15:0] word;
    int          bits;
    int          st_len;
    int          start;
  } frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  show_if bus ();

  show #(
    .SCAN_DIV  (SCAN),
    .SHIFT_DIV (SDIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  frame_t      q[$];
  int          cyc = 0;
  int          bits = 0;
  int          st_len = 0;
  int          start = 0;
  int          rises = 0;
  int          overlap = 0;
  int          unstable = 0;
  logic [15:0] cur = 16'h0;
  logic        sh_prev = 1'b0;
  logic        st_prev = 1'b0;
  logic        ds_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Decode frames off the 74HC595 lines.
  always @(negedge clk) begin
    if (!reset_n) begin
      bits    = 0;
      st_len  = 0;
      cur     = 16'h0;
      sh_prev = 1'b0;
      st_prev = 1'b0;
      ds_prev = 1'b0;
    end else begin
      if (bus.sh_cp && bus.st_cp) overlap++;
      if (bus.sh_cp && sh_prev && bus.ds != ds_prev) unstable++;
      if (bus.sh_cp && !sh_prev) begin
        if (bits == 0) start = cyc;
        cur = {cur[14:0], bus.ds};
        bits++;
        rises++;
      end
      if (bus.st_cp) st_len++;
      if (!bus.st_cp && st_prev) begin
        q.push_back('{cur, bits, st_len, start});
        bits   = 0;
        st_len = 0;
      end
      sh_prev = bus.sh_cp;
      st_prev = bus.st_cp;
      ds_prev = bus.ds;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(logic [31:0] d, int pos);
    logic [7:0] seg;
    logic [3:0] n;
    n   = 4'((d >> (4 * pos)) & 32'hF);
    seg = glyph[n];
`ifdef SHOW_LEADING_ZERO_BLANK_EN
    if (pos != 0 && (d >> (4 * pos)) == 0) seg = 8'hFF;
`endif
    return {seg, ~(8'h01 << pos)};
  endfunction

  task automatic do_reset(logic [31:0] d, logic e);
    reset_n  = 1'b0;
    bus.en   = e;
    bus.data = d;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sh_cp", 32'(bus.sh_cp), 0);
    check("rst_st_cp", 32'(bus.st_cp), 0);
    check("rst_ds", 32'(bus.ds), 0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_frames(int n);
    int k;
    k = 0;
    while (q.size() < n && k < 20 * SCAN) begin
      @(posedge clk);
      k++;
    end
    if (q.size() < n) check("frame_timeout", 32'(q.size()), 32'(n));
  endtask

  task automatic run_scan(string tag, logic [31:0] d, int n);
    do_reset(d, 1'b1);
    wait_frames(n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      check({tag, "_word"}, 32'(q[i].word), 32'(model(d, i % 8)));
      if (i > 0)
        check({tag, "_period"}, 32'(q[i].start - q[i-1].start), SCAN);
    end
  endtask

  initial begin
    int saved;
    int k;
    logic [31:0] d;

    bus.en   = 1'b0;
    bus.data = 32'h0;

    do_reset(32'h0000_0003, 1'b1);
    wait_frames(1);
    if (q.size() > 0) begin
      check("first_word", 32'(q[0].word), 32'h0000_B0FE);
      check("first_bits", 32'(q[0].bits), 16);
      check("first_st_len", 32'(q[0].st_len), SDIV);
    end

    run_scan("abcd", 32'h1234_ABCD, 9);
    run_scan("f0", 32'h0000_00F0, 8);
    run_scan("zero", 32'h0000_0000, 8);
    for (int r = 0; r < 3; r++) begin
      d = $urandom;
      if (r == 1) d = d & 32'h0000_0FFF;
      run_scan("rand", d, 8);
    end

    // en dropped mid-frame on digit 2.
    d = $urandom;
    do_reset(d, 1'b1);
    k = 0;
    while (!(q.size() == 2 && bits == 5) && k < 10 * SCAN) begin
      @(posedge clk);
      k++;
    end
    check("en_drop_reach", 32'(bits), 5);
    bus.en = 1'b0;
    wait_frames(3);
    if (q.size() > 2) begin
      check("en_drop_word", 32'(q[2].word), 32'(model(d, 2)));
      check("en_drop_bits", 32'(q[2].bits), 16);
    end
    saved = rises;
    repeat (3 * SCAN) @(posedge clk);
    check("idle_no_shift", 32'(rises), 32'(saved));
    check("idle_no_frame", 32'(q.size()), 3);
    bus.en = 1'b1;
    wait_frames(4);
    if (q.size() > 3)
      check("resume_word", 32'(q[3].word), 32'(model(d, 3)));

    // Reset pulsed while shifting.
    d = 32'h89AB_CDEF;
    do_reset(d, 1'b1);
    wait_frames(2);
    k = 0;
    while (!(bits == 8 && bus.sh_cp) && k < 10 * SCAN) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_sh_cp_high", 32'(bus.sh_cp), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_sh_cp", 32'(bus.sh_cp), 0);
    check("async_st_cp", 32'(bus.st_cp), 0);
    check("async_ds", 32'(bus.ds), 0);
    repeat (2) @(posedge clk);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    wait_frames(1);
    if (q.size() > 0)
      check("restart_word", 32'(q[0].word), 32'(model(d, 0)));

    check("sh_st_overlap", 32'(overlap), 0);
    check("ds_unstable", 32'(unstable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/show.md
SHOW -- requirements
Module: Show

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot (1 ms at 50 MHz); SHALL be >= 16*2*SHIFT_DIV + SHIFT_DIV.
REQ-002 Parameter SHIFT_DIV, default 2, clk cycles per half-period of sh_cp and per st_cp high pulse; SHALL be >= 1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  scan enable; 1 = frames run.
REQ-006 data  input  32  value to display, 8 hex digits; digit i = data[4i+3:4i], digit 0 rightmost.
REQ-007 sh_cp  output  1  shift clock to two chained 74HC595; data captured on its rising edge.
REQ-008 st_cp  output  1  storage-register latch clock to the 74HC595 chain.
REQ-009 ds  output  1  serial data to the first 74HC595.
REQ-010 One clock domain; reset is asynchronous and active-low (clk, reset_n).

Function
REQ-011 Module SHALL time-multiplex 8 digits, one per slot, digit index 0,1,...,7,0 (wrap after 7).
REQ-012 Each frame SHALL shift 16-bit word W = {SEG[7:0], SEL[7:0]} MSB first (W[15] first).
REQ-013 SEG = {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off).
REQ-014 Hex encoding (SEG hex): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E; blank FF.
REQ-015 SEL one-hot active-low: bit i = 0 for digit i, all other bits 1.
REQ-016 Nibble and blanking decision SHALL be sampled from data in the frame's first cycle; later data changes affect only later frames.
REQ-017 States: IDLE, SHIFT, LATCH, WAIT.
REQ-018 IDLE: when en=1, enter SHIFT next cycle (slot timer starts at 0 on that cycle); when en=0, remain in IDLE.
REQ-019 SHIFT, per bit: ds set to the bit and sh_cp=0 for SHIFT_DIV cycles, then sh_cp=1 for SHIFT_DIV cycles with ds held; 16 bits, then LATCH.
REQ-020 LATCH: sh_cp=0, st_cp=1 for SHIFT_DIV cycles, then st_cp=0, enter WAIT.
REQ-021 WAIT: outputs low; when slot timer reaches SCAN_DIV-1, advance digit index; if en=1, start next frame next cycle, else go to IDLE.
REQ-022 Frame start-to-start period SHALL be exactly SCAN_DIV cycles while en stays 1.
REQ-023 en deasserted mid-frame SHALL NOT abort the frame; frame and slot complete, then IDLE; digit index preserved.
REQ-024 st_cp and sh_cp SHALL never be high in the same cycle.

Reset
REQ-025 While reset_n=0: sh_cp=0, st_cp=0, ds=0, state IDLE, digit index 0, all counters 0.
REQ-026 Reset asserted mid-frame SHALL abort immediately; after release the first frame is digit 0.

Configuration
REQ-027 Macro SHOW_LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero nibble SHALL send SEG=FF; digit 0 is never blanked (data=0 shows single "0").
REQ-028 Macro undefined: all 8 digits SHALL always show their hex glyph, including leading zeros.

Verification (SCAN_DIV=100, SHIFT_DIV=2)
REQ-029 Reset hold, release with en=1, data=32'h0000_0003 -> first frame W=16'hB0FE, 16 sh_cp rising edges, then one st_cp pulse of 2 cycles.
REQ-030 data=32'h1234_ABCD, en=1, 8 slots -> words C6.../A1FE, C6FD, 83FB, 88F7, 99EF, B0DF, A4BF, F97F in order; frame starts exactly 100 cycles apart.
REQ-031 With SHOW_LEADING_ZERO_BLANK_EN, data=32'h0000_00F0 -> digit 0 C0FE, digit 1 8EFD, digits 2-7 SEG=FF; without macro digits 2-7 SEG=C0.
REQ-032 en dropped at shifted bit 5 of digit 2 -> frame completes with latch, no further sh_cp edges; en re-raised -> next frame is digit 3.
REQ-033 reset_n pulsed low during SHIFT -> all outputs 0 asynchronously; after release scan restarts at digit 0.
REQ-034 Continuous check every cycle: sh_cp and st_cp never both 1; ds stable while sh_cp=1.
